addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Round-robin arbiter and sequencer that shares a single registered add/subtract datapath between two requesters. Each requester presents operands and an operation select. The block grants one request at a time, computes `a+b` or `a-b` together with a carry/borrow flag, and returns the result over a valid/ready response channel tagged with the owner ID. It sits between the two client units and the arithmetic resource, so neither client needs its own adder/subtractor.

## Interface
- `WIDTH`, default 8, operand/result width in bits (≥2).
- `clk` in 1, single clock; all state updates on rising edge.
- `rst_n` in 1, reset, synchronous and active-low.
- `req0` in 1, requester 0 request; held high until `gnt0` observed.
- `sub0` in 1, requester 0 operation: 0 = add, 1 = subtract.
- `a0`, `b0` in WIDTH, requester 0 operands.
- `req1`, `sub1`, `a1`, `b1`, same as above for requester 1.
- `gnt0`, `gnt1` out 1, one-cycle grant pulse; operands were latched at the edge that raised it.
- `rsp_valid` out 1, result available.
- `rsp_id` out 1, owner of current result (0 or 1).
- `rsp_ready` in 1, owner accepts result.
- `y` out WIDTH, result, modulo 2^WIDTH.
- `cout` out 1, add: carry out of bit WIDTH-1; subtract: borrow (1 iff a < b unsigned).
- `busy` out 1, high in any state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `req` is high at the edge, select a winner, latch its `a`, `b`, `sub` and ID, and go to EXEC. Otherwise stay in IDLE.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesters: the one not granted last wins.
  - Last-grant pointer resets to 1, so requester 0 wins the first tie.
  - Pointer updates only on a grant.
- EXEC: `gnt<id>` is high this cycle only. The datapath computes a (WIDTH+1)-bit result from the latched operands:
  - `y` = low WIDTH bits.
  - `cout` = bit WIDTH for add, or bit WIDTH of the zero-extended difference (borrow) for subtract.
  - Register `y` and `cout`, then go to RESP.
- RESP: `rsp_valid`=1, and `y`, `cout`, `rsp_id` stay stable. When `rsp_ready` is high at the edge, go to IDLE.
- Requests arriving outside IDLE are not sampled. A requester keeps `req` high and is considered in the next IDLE cycle.
- A requester must drop `req` in the cycle after `gnt`. If `req` stays high, the block treats it as a new request.
- Reset (`rst_n`=0 at an edge), in any state, including mid-transaction:
  - State goes to IDLE and the pending transaction is discarded.
  - `gnt0`/`gnt1`/`rsp_valid`/`busy`/`y`/`cout`/`rsp_id` all go to 0.
  - Last-grant pointer goes to 1.

## Timing
- Reset values: all outputs 0.
- Request sampled at edge N (state IDLE). Then:
  - Cycle N+1: EXEC, `gnt` high, `busy`=1.
  - Cycle N+2: RESP, `rsp_valid`=1, result valid.
- Latency from request edge to `rsp_valid`: 2 cycles.
- If `rsp_ready` is already high in the first RESP cycle, the response lasts 1 cycle and the block is back in IDLE at N+3. The next request is sampled at that edge, so peak throughput is 1 operation per 3 cycles.
- `rsp_ready` outside RESP is ignored.
- `y`/`cout` hold their last values in IDLE until the next EXEC→RESP update; only reset clears them.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset and single add:
  - Stimulus: hold `rst_n`=0 for 2 cycles, check all outputs 0. Then `req0`=1, `a0`=8'h0F, `b0`=8'h01, `sub0`=0, `rsp_ready`=1.
  - Required: `gnt0` pulse at N+1; `y`=8'h10, `cout`=0, `rsp_id`=0, `rsp_valid` at N+2.
- Carry and borrow:
  - Add 8'hFF+8'h01 → `y`=8'h00, `cout`=1.
  - Subtract 8'h05-8'h07 → `y`=8'hFE, `cout`=1.
  - Subtract 8'h07-8'h05 → `y`=8'h02, `cout`=0.
- Simultaneous requests:
  - Stimulus: `req0` and `req1` held high for four operations.
  - Required: grant order 0,1,0,1; each `rsp_id` matches its grant.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles in RESP while `req1` is pending.
  - Required: `y`/`cout`/`rsp_id` stable; no `gnt1` until the cycle after `rsp_ready` is accepted.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 during EXEC.
  - Required: next cycle all outputs 0, state IDLE, no `rsp_valid`. After release, a tie grants requester 0.
- Random soak:
  - Stimulus: 2000 random operand/op/req/`rsp_ready` cycles, WIDTH=8 and WIDTH=4.
  - Required: every result matches the reference model; no requester starved for more than 2 grants.

Source files
------------

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter sharing one registered add/subtract
// datapath between two requesters. A grant latches the winner's operands,
// the next cycle computes and registers the result, and the result is then
// held on a valid/ready response channel tagged with the owner ID.
module addsub_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             sub0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic             sub1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rsp_valid,
    output logic             rsp_id,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;        // requester granted most recently
    logic             owner_q, owner_d;      // requester owning the latched operation
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             op_sub_q, op_sub_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;

    logic             any_req;
    logic             winner;
    logic [WIDTH:0]   result_ext;

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_q;
        end else begin
            winner = req1;
        end
    end

    // Shared datapath on the latched operands. Bit WIDTH is the carry for an
    // add and, since both operands are zero-extended, the borrow for a subtract.
    always_comb begin
        if (op_sub_q) begin
            result_ext = {1'b0, opa_q} - {1'b0, opb_q};
        end else begin
            result_ext = {1'b0, opa_q} + {1'b0, opb_q};
        end
    end

    // Next-state and registered-output logic for the IDLE/EXEC/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        op_sub_d    = op_sub_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        y_d         = y_q;
        cout_d      = cout_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = EXEC;
                    last_d   = winner;
                    owner_d  = winner;
                    opa_d    = winner ? a1 : a0;
                    opb_d    = winner ? b1 : b0;
                    op_sub_d = winner ? sub1 : sub0;
                    gnt0_d   = ~winner;
                    gnt1_d   = winner;
                end
            end
            EXEC: begin
                state_d     = RESP;
                y_d         = result_ext[WIDTH-1:0];
                cout_d      = result_ext[WIDTH];
                rsp_id_d    = owner_q;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Single state register: synchronous active-low reset discards any
    // in-flight transaction and returns the tie pointer to requester 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            op_sub_q    <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            y_q         <= '0;
            cout_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            op_sub_q    <= op_sub_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            y_q         <= y_d;
            cout_q      <= cout_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign y         = y_q;
    assign cout      = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed and random checks for addsub_arbiter; a WIDTH=8 and a WIDTH=4
// instance run in lock-step on the same control inputs.
module tb_addsub_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, sub0, req1, sub1, rsp_ready;
    logic [7:0] a0, b0, a1, b1;

    logic       gnt0, gnt1, rsp_valid, rsp_id, cout, busy;
    logic [7:0] y;
    logic       gnt0_4, gnt1_4, rsp_valid_4, rsp_id_4, cout_4, busy_4;
    logic [3:0] y_4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .sub0(sub0), .a0(a0), .b0(b0),
        .req1(req1), .sub1(sub1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .y(y), .cout(cout), .busy(busy)
    );

    addsub_arbiter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .sub0(sub0), .a0(a0[3:0]), .b0(b0[3:0]),
        .req1(req1), .sub1(sub1), .a1(a1[3:0]), .b1(b1[3:0]),
        .gnt0(gnt0_4), .gnt1(gnt1_4), .rsp_valid(rsp_valid_4), .rsp_id(rsp_id_4),
        .rsp_ready(rsp_ready), .y(y_4), .cout(cout_4), .busy(busy_4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One uncontended operation with rsp_ready already high.
    task automatic do_op(input logic id, input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ey, input logic ec);
        if (id) begin
            req1 = 1'b1; sub1 = s; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; sub0 = s; a0 = a; b0 = b;
        end
        rsp_ready = 1'b1;
        tick();
        chk("op_gnt0", gnt0, !id);
        chk("op_gnt1", gnt1, id);
        chk("op_busy_exec", busy, 1);
        chk("op_valid_exec", rsp_valid, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        chk("op_valid", rsp_valid, 1);
        chk("op_y", y, ey);
        chk("op_cout", cout, ec);
        chk("op_id", rsp_id, id);
        tick();
        chk("op_valid_idle", rsp_valid, 0);
        chk("op_busy_idle", busy, 0);
        chk("op_y_hold", y, ey);
    endtask

    // Reference result for a WIDTH-bit add/subtract.
    function automatic logic [8:0] ref_op(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
        int mask;
        int ia;
        int ib;
        int r;
        logic c;
        mask = (1 << w) - 1;
        ia = int'(a) & mask;
        ib = int'(b) & mask;
        if (s) begin
            r = ia - ib;
            c = (ia < ib);
        end else begin
            r = ia + ib;
            c = (r > mask);
        end
        r = r & mask;
        return {c, r[7:0]};
    endfunction

    logic [7:0] exp_y_tie [4];
    logic       exp_c_tie [4];

    initial begin
        logic       m_st_exec, m_st_resp, m_last, m_owner, m_sub, m_id;
        logic       eg0, eg1;
        logic [7:0] m_a, m_b, m_y8;
        logic [3:0] m_y4;
        logic       m_c8, m_c4;
        logic [8:0] r;
        int         wait0, wait1;

        rst_n = 1'b0;
        req0 = 0; sub0 = 0; a0 = '0; b0 = '0;
        req1 = 0; sub1 = 0; a1 = '0; b1 = '0;
        rsp_ready = 0;

        // Reset state
        tick();
        tick();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_y", y, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Single add, then carry and borrow cases; the last op leaves the pointer at 1
        do_op(1'b0, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0);
        do_op(1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1);
        do_op(1'b1, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b1);
        do_op(1'b1, 1'b1, 8'h07, 8'h05, 8'h02, 1'b0);

        // Both requesters held high for four operations: order 0,1,0,1
        req0 = 1; sub0 = 0; a0 = 8'h10; b0 = 8'h03;
        req1 = 1; sub1 = 1; a1 = 8'h20; b1 = 8'h30;
        exp_y_tie = '{8'h13, 8'hF0, 8'h13, 8'hF0};
        exp_c_tie = '{1'b0, 1'b1, 1'b0, 1'b1};
        rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tie_gnt0", gnt0, (i % 2) == 0);
            chk("tie_gnt1", gnt1, (i % 2) == 1);
            tick();
            chk("tie_id", rsp_id, (i % 2) == 1);
            chk("tie_y", y, exp_y_tie[i]);
            chk("tie_cout", cout, exp_c_tie[i]);
            tick();
            chk("tie_idle", busy, 0);
        end
        req0 = 0;
        req1 = 0;

        // Backpressure with requester 1 pending
        rsp_ready = 0;
        req0 = 1; sub0 = 0; a0 = 8'h33; b0 = 8'h11;
        tick();
        chk("bp_gnt0", gnt0, 1);
        req0 = 0;
        req1 = 1; sub1 = 1; a1 = 8'h09; b1 = 8'h0A;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_y", y, 8'h44);
            chk("bp_cout", cout, 0);
            chk("bp_id", rsp_id, 0);
            chk("bp_no_gnt1", gnt1, 0);
        end
        rsp_ready = 1;
        tick();
        chk("bp_accept_valid", rsp_valid, 0);
        chk("bp_accept_gnt1", gnt1, 0);
        tick();
        chk("bp_gnt1", gnt1, 1);
        req1 = 0;
        tick();
        chk("bp2_y", y, 8'hFF);
        chk("bp2_cout", cout, 1);
        chk("bp2_id", rsp_id, 1);
        tick();

        // Reset during EXEC; the grant taken just before it went to requester 0
        req0 = 1; sub0 = 0; a0 = 8'h01; b0 = 8'h02;
        req1 = 1; sub1 = 0; a1 = 8'h03; b1 = 8'h04;
        tick();
        chk("mid_gnt0", gnt0, 1);
        rst_n = 0;
        tick();
        chk("mid_rst_gnt0", gnt0, 0);
        chk("mid_rst_gnt1", gnt1, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_id", rsp_id, 0);
        rst_n = 1;
        tick();
        chk("post_rst_gnt0", gnt0, 1);
        chk("post_rst_gnt1", gnt1, 0);
        chk("post_rst_valid", rsp_valid, 0);
        req0 = 0;
        req1 = 0;
        tick();
        chk("post_rst_y", y, 8'h03);
        tick();

        // Random soak against a transaction model, both widths
        rst_n = 0;
        tick();
        rst_n = 1;
        m_st_exec = 0; m_st_resp = 0; m_last = 1; m_owner = 0; m_sub = 0; m_id = 0;
        m_a = '0; m_b = '0; m_y8 = '0; m_y4 = '0; m_c8 = 0; m_c4 = 0;
        wait0 = 0; wait1 = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!req0 && $urandom_range(0, 1) == 1) begin
                req0 = 1; sub0 = 1'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
            end
            if (!req1 && $urandom_range(0, 1) == 1) begin
                req1 = 1; sub1 = 1'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();

            eg0 = 0;
            eg1 = 0;
            if (m_st_resp) begin
                if (rsp_ready) m_st_resp = 0;
            end else if (m_st_exec) begin
                r = ref_op(8, m_sub, m_a, m_b);
                m_y8 = r[7:0]; m_c8 = r[8];
                r = ref_op(4, m_sub, m_a, m_b);
                m_y4 = r[3:0]; m_c4 = r[8];
                m_id = m_owner;
                m_st_exec = 0;
                m_st_resp = 1;
            end else if (req0 || req1) begin
                m_owner = (req0 && req1) ? !m_last : req1;
                m_last = m_owner;
                m_a = m_owner ? a1 : a0;
                m_b = m_owner ? b1 : b0;
                m_sub = m_owner ? sub1 : sub0;
                eg0 = !m_owner;
                eg1 = m_owner;
                m_st_exec = 1;
            end

            chk("soak8", {gnt0, gnt1, rsp_valid, busy, rsp_id, cout, y},
                {eg0, eg1, m_st_resp, m_st_exec | m_st_resp, m_id, m_c8, m_y8});
            chk("soak4", {gnt0_4, gnt1_4, rsp_valid_4, busy_4, rsp_id_4, cout_4, y_4},
                {eg0, eg1, m_st_resp, m_st_exec | m_st_resp, m_id, m_c4, m_y4});

            if (gnt0) begin
                wait0 = 0;
                if (req1) wait1++;
                chk("starve1", wait1 > 2, 0);
            end
            if (gnt1) begin
                wait1 = 0;
                if (req0) wait0++;
                chk("starve0", wait0 > 2, 0);
            end
            if (eg0) req0 = 0;
            if (eg1) req1 = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
